// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and an optional two-entry skid buffer.
// When SKID=1, in_ready comes from a flop. Legacy flush and hold controls are kept.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             mainValid;
    logic             skidValid;
    logic             mainValidNxt;
    logic             skidValidNxt;
    logic [WIDTH-1:0] mainData;
    logic [WIDTH-1:0] skidData;
    logic [WIDTH-1:0] mainDataNxt;
    logic [WIDTH-1:0] skidDataNxt;
    logic             acc;
    logic             pop;

    assign acc = in_valid & in_ready;
    assign pop = mainValid & out_ready & ~hold;

    generate
        if (SKID != 0) begin : gSkid
            logic readyQ;

            // Ready is precomputed from the next skid occupancy so upstream sees a plain flop.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    readyQ <= 1'b1;
                end else begin
                    readyQ <= ~skidValidNxt;
                end
            end

            assign in_ready = readyQ;
        end else begin : gNoSkid
            assign in_ready = ~mainValid | pop;
        end
    endgenerate

    // Next-state selection for the main and skid entries.
    always_comb begin
        mainValidNxt = mainValid;
        skidValidNxt = skidValid;
        mainDataNxt  = mainData;
        skidDataNxt  = skidData;
        if (SKID != 0) begin
            if (skidValid) begin
                if (pop) begin
                    mainDataNxt  = skidData;
                    skidValidNxt = 1'b0;
                end
            end else if (mainValid) begin
                if (acc && pop) begin
                    mainDataNxt = in_data;
                end else if (acc) begin
                    skidValidNxt = 1'b1;
                    skidDataNxt  = in_data;
                end else if (pop) begin
                    mainValidNxt = 1'b0;
                end
            end else if (acc) begin
                mainValidNxt = 1'b1;
                mainDataNxt  = in_data;
            end
        end else begin
            skidValidNxt = 1'b0;
            if (acc) begin
                mainValidNxt = 1'b1;
                mainDataNxt  = in_data;
            end else if (pop) begin
                mainValidNxt = 1'b0;
            end
        end
    end

    // Reset and flush clear the stage identically. Reset wins, but the outcome is the same.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainData  <= RESET_VAL;
            skidData  <= RESET_VAL;
        end else begin
            mainValid <= mainValidNxt;
            skidValid <= skidValidNxt;
            mainData  <= mainDataNxt;
            skidData  <= skidDataNxt;
        end
    end

    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign count     = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed table and corner sequences, then random stress.
// Both SKID builds are checked against a queue-based occupancy model.
module tb_pipe_stage_skid;

    localparam logic [31:0] RV = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        inReady1, outValid1, inReady0, outValid0;
    logic [31:0] outData1, outData0;
    logic [1:0]  count1, count0;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .SKID(1), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(inReady1), .in_data(in_data),
        .out_valid(outValid1), .out_ready(out_ready), .out_data(outData1),
        .count(count1)
    );

    pipe_stage_skid #(.WIDTH(32), .SKID(0), .RESET_VAL(RV)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(inReady0), .in_data(in_data),
        .out_valid(outValid0), .out_ready(out_ready), .out_data(outData0),
        .count(count0)
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        hld;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        chkOd;
        logic        ir;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic iv, logic [31:0] id, logic ordy, logic hld, logic fl,
                                logic ov, logic [31:0] od, logic chkOd, logic ir, logic [1:0] cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.hld = hld; v.fl = fl;
        v.ov = ov; v.od = od; v.chkOd = chkOd; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic iv, logic [31:0] id, logic ordy, logic hld, logic fl);
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; hold = hld; flush = fl;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; hold = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Expected outputs are those seen before the edge that applies the row's inputs.
        tbl[0]  = mk(1, 32'h100, 1, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[1]  = mk(1, 32'h104, 1, 0, 0,  1, 32'h100, 1, 1, 1);
        tbl[2]  = mk(1, 32'h108, 1, 0, 0,  1, 32'h104, 1, 1, 1);
        tbl[3]  = mk(0, 32'h0,   1, 0, 0,  1, 32'h108, 1, 1, 1);
        tbl[4]  = mk(0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[5]  = mk(1, 32'hA,   0, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[6]  = mk(1, 32'hB,   0, 0, 0,  1, 32'hA,   1, 1, 1);
        tbl[7]  = mk(1, 32'hC,   0, 0, 0,  1, 32'hA,   1, 0, 2);
        tbl[8]  = mk(1, 32'hC,   1, 0, 0,  1, 32'hA,   1, 0, 2);
        tbl[9]  = mk(1, 32'hC,   1, 0, 0,  1, 32'hB,   1, 1, 1);
        tbl[10] = mk(0, 32'h0,   1, 0, 0,  1, 32'hC,   1, 1, 1);
        tbl[11] = mk(0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[12] = mk(1, 32'h1,   0, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[13] = mk(1, 32'h2,   0, 0, 0,  1, 32'h1,   1, 1, 1);
        tbl[14] = mk(1, 32'hDEAD,0, 0, 1,  1, 32'h1,   1, 0, 2);
        tbl[15] = mk(1, 32'hDEAD,1, 0, 1,  0, RV,      1, 1, 0);
        tbl[16] = mk(0, 32'h0,   1, 0, 0,  0, RV,      1, 1, 0);
        tbl[17] = mk(1, 32'h55,  1, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[18] = mk(0, 32'h0,   1, 1, 0,  1, 32'h55,  1, 1, 1);
        tbl[19] = mk(0, 32'h0,   1, 1, 0,  1, 32'h55,  1, 1, 1);
        tbl[20] = mk(0, 32'h0,   1, 1, 0,  1, 32'h55,  1, 1, 1);
        tbl[21] = mk(0, 32'h0,   1, 0, 0,  1, 32'h55,  1, 1, 1);
        tbl[22] = mk(0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[23] = mk(1, 32'h60,  1, 1, 0,  0, 32'h0,   0, 1, 0);
        tbl[24] = mk(1, 32'h61,  1, 1, 0,  1, 32'h60,  1, 1, 1);
        tbl[25] = mk(1, 32'h62,  1, 1, 0,  1, 32'h60,  1, 0, 2);
        tbl[26] = mk(0, 32'h0,   1, 0, 0,  1, 32'h60,  1, 0, 2);
        tbl[27] = mk(0, 32'h0,   1, 0, 0,  1, 32'h61,  1, 1, 1);
        tbl[28] = mk(0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1, 0);
        tbl[29] = mk(0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1, 0);

        doReset();
        #1;
        chk("reset out_valid", 32'(outValid1), 32'(1'b0));
        chk("reset out_data",  outData1, RV);
        chk("reset in_ready",  32'(inReady1), 32'(1'b1));
        chk("reset count",     32'(count1), 32'd0);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].hld, tbl[i].fl);
            chk($sformatf("row%0d out_valid", i), 32'(outValid1), 32'(tbl[i].ov));
            chk($sformatf("row%0d in_ready", i),  32'(inReady1),  32'(tbl[i].ir));
            chk($sformatf("row%0d count", i),     32'(count1),    32'(tbl[i].cnt));
            if (tbl[i].chkOd)
                chk($sformatf("row%0d out_data", i), outData1, tbl[i].od);
        end

        // SKID=0: combinational ready while popping, single entry only.
        doReset();
        drive(1, 32'h70, 1, 0, 0);
        chk("s0 empty in_ready", 32'(inReady0), 32'(1'b1));
        chk("s0 empty count",    32'(count0),   32'd0);
        drive(1, 32'h77, 1, 0, 0);
        chk("s0 out_valid",       32'(outValid0), 32'(1'b1));
        chk("s0 out_data 70",     outData0, 32'h70);
        chk("s0 pop in_ready",    32'(inReady0), 32'(1'b1));
        drive(1, 32'h78, 0, 0, 0);
        chk("s0 out_data 77",     outData0, 32'h77);
        chk("s0 count one",       32'(count0), 32'd1);
        chk("s0 stall in_ready",  32'(inReady0), 32'(1'b0));
        drive(1, 32'h79, 1, 1, 0);
        chk("s0 hold in_ready",   32'(inReady0), 32'(1'b0));
        chk("s0 hold out_data",   outData0, 32'h77);
        drive(0, 32'h0, 1, 0, 0);
        chk("s0 count max",       32'(count0), 32'd1);
        chk("s0 data kept",       outData0, 32'h77);

        // Random stress against capacity-bounded queue models.
        doReset();
        q1.delete();
        q0.delete();
        for (int c = 0; c < 10000; c++) begin
            bit rdy1, rdy0, pop1, pop0, acc1, acc0;
            @(negedge clk);
            rst       = ($urandom_range(0, 999) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            hold      = $urandom_range(0, 7) == 0;
            flush     = $urandom_range(0, 49) == 0;
            #1;
            pop1 = (q1.size() > 0) && out_ready && !hold;
            rdy1 = q1.size() < 2;
            acc1 = in_valid && rdy1;
            pop0 = (q0.size() > 0) && out_ready && !hold;
            rdy0 = (q0.size() == 0) || pop0;
            acc0 = in_valid && rdy0;

            chk("rnd1 out_valid", 32'(outValid1), 32'(q1.size() > 0));
            chk("rnd1 in_ready",  32'(inReady1),  32'(rdy1));
            chk("rnd1 count",     32'(count1),    32'(q1.size()));
            if (q1.size() > 0) chk("rnd1 out_data", outData1, q1[0]);
            chk("rnd1 skid implies main", 32'(count1 != 2'd2 || outValid1), 32'd1);
            chk("rnd0 out_valid", 32'(outValid0), 32'(q0.size() > 0));
            chk("rnd0 in_ready",  32'(inReady0),  32'(rdy0));
            chk("rnd0 count",     32'(count0),    32'(q0.size()));
            if (q0.size() > 0) chk("rnd0 out_data", outData0, q0[0]);

            @(posedge clk);
            if (rst || flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (acc1) q1.push_back(in_data);
                if (pop0) void'(q0.pop_front());
                if (acc0) q0.push_back(in_data);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
